// File: rtl/switch_allocator.sv
// switch_allocator: per-output wormhole switch allocator for the 5-port mesh router.
// Each output port runs an IDLE/LOCKED FSM. In IDLE it arbitrates round-robin among
// HEAD flits; after a HEAD grant it stays locked to the winning input until that
// input's TAIL flit is granted. Dequeue grants (in_grant) are combinational; crossbar
// selects and output valids are registered one cycle later.
//
// Optional build macro: SA_PROTO_CHECK_EN
//   defined   -> sticky proto_err flags malformed flit streams
//   undefined -> proto_err tied low, no checking logic
//
// Per-output FSM:
//   state     | meaning
//   ST_IDLE   | output free; round-robin among HEAD requesters with credit
//   ST_LOCKED | output owned by owner_q; only its BODY/TAIL flits are granted

module switch_allocator #(
  parameter int NUM_PORTS = 5,
  parameter int OP_SIZE   = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           in_valid,
  input  logic [2*NUM_PORTS-1:0]         in_flit_type,
  input  logic [OP_SIZE*NUM_PORTS-1:0]   in_op_port,
  input  logic [NUM_PORTS-1:0]           credit_avail,
  output logic [NUM_PORTS-1:0]           in_grant,
  output logic [OP_SIZE*NUM_PORTS-1:0]   xbar_sel,
  output logic [NUM_PORTS-1:0]           out_valid,
  output logic                           proto_err
);

  localparam logic [1:0] FT_HEAD = 2'b00;
  localparam logic [1:0] FT_BODY = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b10;
  localparam logic [1:0] FT_BAD  = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state_q  [NUM_PORTS];
  logic [OP_SIZE-1:0] owner_q  [NUM_PORTS];
  logic [OP_SIZE-1:0] rr_ptr_q [NUM_PORTS];

  logic [1:0]         ftype  [NUM_PORTS];
  logic [OP_SIZE-1:0] op     [NUM_PORTS];
  logic [NUM_PORTS-1:0] req_ok;

  logic [NUM_PORTS-1:0] hit;
  logic [OP_SIZE-1:0]   win [NUM_PORTS];
  logic [NUM_PORTS-1:0] tail_fire;
  logic [NUM_PORTS-1:0] gnt [NUM_PORTS];

  // Slice the flattened input buses and qualify well-formed requests
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      ftype[i]  = in_flit_type[2*i +: 2];
      op[i]     = in_op_port[OP_SIZE*i +: OP_SIZE];
      req_ok[i] = in_valid[i] && (ftype[i] != FT_BAD) && (op[i] < OP_SIZE'(NUM_PORTS));
    end
  end

  // Per-output arbitration: round-robin over HEADs when idle, owner-only when locked
  always_comb begin : p_arb
    int idx;
    idx = 0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      hit[o]       = 1'b0;
      win[o]       = '0;
      tail_fire[o] = 1'b0;
      if (!rst && credit_avail[o]) begin
        if (state_q[o] == ST_IDLE) begin
          // Scan from farthest to nearest so the nearest-to-pointer requester wins.
          for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q[o]) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (req_ok[idx] && (op[idx] == OP_SIZE'(o)) && (ftype[idx] == FT_HEAD)) begin
              hit[o] = 1'b1;
              win[o] = OP_SIZE'(idx);
            end
          end
        end else begin
          if (req_ok[owner_q[o]] && (op[owner_q[o]] == OP_SIZE'(o)) &&
              ((ftype[owner_q[o]] == FT_BODY) || (ftype[owner_q[o]] == FT_TAIL))) begin
            hit[o]       = 1'b1;
            win[o]       = owner_q[o];
            tail_fire[o] = (ftype[owner_q[o]] == FT_TAIL);
          end
        end
      end
    end
  end

  // Expand each output's winner into a one-hot grant row
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      gnt[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        gnt[o][i] = hit[o] && (win[o] == OP_SIZE'(i));
      end
    end
  end

  // Merge grant rows; an input requests one output, so at most one row is set per input
  always_comb begin
    in_grant = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      in_grant = in_grant | gnt[o];
    end
  end

  // Output FSMs: claim on HEAD grant, release and advance pointer on TAIL grant
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o]  <= ST_IDLE;
        owner_q[o]  <= '0;
        rr_ptr_q[o] <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        case (state_q[o])
          ST_IDLE: begin
            if (hit[o]) begin
              state_q[o] <= ST_LOCKED;
              owner_q[o] <= win[o];
            end
          end
          ST_LOCKED: begin
            if (tail_fire[o]) begin
              state_q[o]  <= ST_IDLE;
              rr_ptr_q[o] <= (owner_q[o] == OP_SIZE'(NUM_PORTS - 1)) ? '0
                                                                     : owner_q[o] + OP_SIZE'(1);
            end
          end
          default: state_q[o] <= ST_IDLE;
        endcase
      end
    end
  end

  // Switch-traversal stage: register valids and crossbar selects for granted outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      xbar_sel  <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        out_valid[o] <= hit[o];
        if (hit[o]) xbar_sel[OP_SIZE*o +: OP_SIZE] <= win[o];
      end
    end
  end

`ifdef SA_PROTO_CHECK_EN
  logic [NUM_PORTS-1:0] owns_lock;
  logic                 proto_hit;
  logic                 proto_err_q;

  // Which inputs currently hold a locked output
  always_comb begin
    owns_lock = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if ((state_q[o] == ST_LOCKED) && (owner_q[o] == OP_SIZE'(i))) owns_lock[i] = 1'b1;
      end
    end
  end

  // Detect malformed flits on any valid input this cycle
  always_comb begin
    proto_hit = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_valid[i]) begin
        if ((ftype[i] == FT_BAD) || (op[i] >= OP_SIZE'(NUM_PORTS))) begin
          proto_hit = 1'b1;
        end else if (((ftype[i] == FT_BODY) || (ftype[i] == FT_TAIL)) && !owns_lock[i]) begin
          proto_hit = 1'b1;
        end else if ((ftype[i] == FT_HEAD) && owns_lock[i]) begin
          proto_hit = 1'b1;
        end
      end
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) proto_err_q <= 1'b0;
    else if (proto_hit) proto_err_q <= 1'b1;
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator. Each scenario drives a per-cycle table of
// inputs plus expected in_grant; expected out_valid/xbar_sel are derived from the
// expected grants, pushed to a scoreboard, and popped after the next clock edge.

module tb_switch_allocator;

  localparam int NP = 5;
  localparam int OS = 3;
  localparam int H = 0, B = 1, T = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   in_valid;
  logic [2*NP-1:0] in_flit_type;
  logic [OS*NP-1:0] in_op_port;
  logic [NP-1:0]   credit_avail;
  logic [NP-1:0]   in_grant;
  logic [OS*NP-1:0] xbar_sel;
  logic [NP-1:0]   out_valid;
  logic            proto_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [NP-1:0]    v;
    logic [2*NP-1:0]  t;
    logic [OS*NP-1:0] o;
    logic [NP-1:0]    c;
    logic [NP-1:0]    g;
  } cyc_t;

  typedef struct {
    logic [NP-1:0]    v;
    logic [OS*NP-1:0] x;
  } exp_t;

  exp_t             sb[$];
  logic [OS*NP-1:0] xsel_model;
  logic             exp_proto;

  switch_allocator #(.NUM_PORTS(NP), .OP_SIZE(OS)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_flit_type (in_flit_type),
    .in_op_port   (in_op_port),
    .credit_avail (credit_avail),
    .in_grant     (in_grant),
    .xbar_sel     (xbar_sel),
    .out_valid    (out_valid),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [2*NP-1:0] ty(int t4, int t3, int t2, int t1, int t0);
    return {2'(t4), 2'(t3), 2'(t2), 2'(t1), 2'(t0)};
  endfunction

  function automatic logic [OS*NP-1:0] op(int o4, int o3, int o2, int o1, int o0);
    return {3'(o4), 3'(o3), 3'(o2), 3'(o1), 3'(o0)};
  endfunction

  function automatic cyc_t cy(logic [NP-1:0] v, logic [2*NP-1:0] t, logic [OS*NP-1:0] o,
                              logic [NP-1:0] c, logic [NP-1:0] g);
    cyc_t r;
    r.v = v; r.t = t; r.o = o; r.c = c; r.g = g;
    return r;
  endfunction

  // Scoreboard model: each expected grant of input i toward its op makes that output
  // valid next cycle with select i; ungranted outputs keep their previous select.
  task automatic push_expect(input logic [NP-1:0] g, input logic [OS*NP-1:0] ops);
    exp_t e;
    int   o;
    e.v = '0;
    for (int i = 0; i < NP; i++) begin
      if (g[i]) begin
        o = int'(ops[OS*i +: OS]);
        e.v[o] = 1'b1;
        xsel_model[OS*o +: OS] = OS'(i);
      end
    end
    e.x = xsel_model;
    sb.push_back(e);
  endtask

  task automatic drive(input cyc_t c);
    in_valid     = c.v;
    in_flit_type = c.t;
    in_op_port   = c.o;
    credit_avail = c.c;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(cy(5'b11111, ty(H, H, H, H, H), op(0, 0, 0, 0, 0), 5'b11111, 5'b00000));
    @(negedge clk); #1;
    checks++;
    if (in_grant !== 5'b00000) begin
      failures++; $display("FAIL reset_grant got=%b exp=00000", in_grant);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 5'b00000 || xbar_sel !== '0 || proto_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs got out_valid=%b xbar_sel=%h proto_err=%b exp 0/0/0",
               out_valid, xbar_sel, proto_err);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(cy(5'b00000, ty(H, H, H, H, H), op(0, 0, 0, 0, 0), 5'b11111, 5'b00000));
    sb.delete();
    xsel_model = '0;
  endtask

  task automatic test_single_packet();
    cyc_t tb[$];
    exp_t e;
    tb.push_back(cy(5'b10000, ty(H, 0, 0, 0, 0), op(1, 0, 0, 0, 0), 5'b11111, 5'b10000));
    tb.push_back(cy(5'b10000, ty(B, 0, 0, 0, 0), op(1, 0, 0, 0, 0), 5'b11111, 5'b10000));
    tb.push_back(cy(5'b10000, ty(T, 0, 0, 0, 0), op(1, 0, 0, 0, 0), 5'b11111, 5'b10000));
    tb.push_back(cy(5'b00001, ty(0, 0, 0, 0, H), op(0, 0, 0, 0, 1), 5'b11111, 5'b00001));
    tb.push_back(cy(5'b00001, ty(0, 0, 0, 0, T), op(0, 0, 0, 0, 1), 5'b11111, 5'b00001));
    tb.push_back(cy(5'b00000, ty(0, 0, 0, 0, 0), op(0, 0, 0, 0, 0), 5'b11111, 5'b00000));
    foreach (tb[k]) begin
      @(negedge clk); drive(tb[k]); #1;
      checks++;
      if (in_grant !== tb[k].g) begin
        failures++; $display("FAIL single_grant cyc=%0d got=%b exp=%b", k, in_grant, tb[k].g);
      end
      push_expect(tb[k].g, tb[k].o);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_valid !== e.v || xbar_sel !== e.x) begin
        failures++;
        $display("FAIL single_out cyc=%0d got v=%b x=%h exp v=%b x=%h", k, out_valid, xbar_sel, e.v, e.x);
      end
    end
  endtask

  task automatic test_contention();
    cyc_t tb[$];
    exp_t e;
    tb.push_back(cy(5'b01101, ty(0, H, H, 0, H), op(0, 2, 2, 0, 2), 5'b11111, 5'b00001));
    tb.push_back(cy(5'b01101, ty(0, H, H, 0, T), op(0, 2, 2, 0, 2), 5'b11111, 5'b00001));
    tb.push_back(cy(5'b01100, ty(0, H, H, 0, 0), op(0, 2, 2, 0, 0), 5'b11111, 5'b00100));
    tb.push_back(cy(5'b01100, ty(0, H, T, 0, 0), op(0, 2, 2, 0, 0), 5'b11111, 5'b00100));
    tb.push_back(cy(5'b01000, ty(0, H, 0, 0, 0), op(0, 2, 0, 0, 0), 5'b11111, 5'b01000));
    tb.push_back(cy(5'b01001, ty(0, T, 0, 0, H), op(0, 2, 0, 0, 2), 5'b11111, 5'b01000));
    tb.push_back(cy(5'b00001, ty(0, 0, 0, 0, H), op(0, 0, 0, 0, 2), 5'b11111, 5'b00001));
    tb.push_back(cy(5'b00001, ty(0, 0, 0, 0, T), op(0, 0, 0, 0, 2), 5'b11111, 5'b00001));
    tb.push_back(cy(5'b00000, ty(0, 0, 0, 0, 0), op(0, 0, 0, 0, 0), 5'b11111, 5'b00000));
    foreach (tb[k]) begin
      @(negedge clk); drive(tb[k]); #1;
      checks++;
      if (in_grant !== tb[k].g) begin
        failures++; $display("FAIL contention_grant cyc=%0d got=%b exp=%b", k, in_grant, tb[k].g);
      end
      push_expect(tb[k].g, tb[k].o);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_valid !== e.v || xbar_sel !== e.x) begin
        failures++;
        $display("FAIL contention_out cyc=%0d got v=%b x=%h exp v=%b x=%h", k, out_valid, xbar_sel, e.v, e.x);
      end
    end
  endtask

  task automatic test_lock_hold();
    cyc_t tb[$];
    exp_t e;
    tb.push_back(cy(5'b00010, ty(0, 0, 0, H, 0), op(0, 0, 0, 0, 0), 5'b11111, 5'b00010));
    tb.push_back(cy(5'b01010, ty(0, H, 0, B, 0), op(0, 0, 0, 0, 0), 5'b11111, 5'b00010));
    tb.push_back(cy(5'b01010, ty(0, H, 0, B, 0), op(0, 0, 0, 0, 0), 5'b11111, 5'b00010));
    tb.push_back(cy(5'b01010, ty(0, H, 0, T, 0), op(0, 0, 0, 0, 0), 5'b11111, 5'b00010));
    tb.push_back(cy(5'b01000, ty(0, H, 0, 0, 0), op(0, 0, 0, 0, 0), 5'b11111, 5'b01000));
    tb.push_back(cy(5'b01000, ty(0, T, 0, 0, 0), op(0, 0, 0, 0, 0), 5'b11111, 5'b01000));
    tb.push_back(cy(5'b00000, ty(0, 0, 0, 0, 0), op(0, 0, 0, 0, 0), 5'b11111, 5'b00000));
    foreach (tb[k]) begin
      @(negedge clk); drive(tb[k]); #1;
      checks++;
      if (in_grant !== tb[k].g) begin
        failures++; $display("FAIL lock_hold_grant cyc=%0d got=%b exp=%b", k, in_grant, tb[k].g);
      end
      push_expect(tb[k].g, tb[k].o);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_valid !== e.v || xbar_sel !== e.x) begin
        failures++;
        $display("FAIL lock_hold_out cyc=%0d got v=%b x=%h exp v=%b x=%h", k, out_valid, xbar_sel, e.v, e.x);
      end
    end
  endtask

  task automatic test_backpressure();
    cyc_t tb[$];
    exp_t e;
    tb.push_back(cy(5'b00100, ty(0, 0, H, 0, 0), op(0, 0, 3, 0, 0), 5'b11111, 5'b00100));
    tb.push_back(cy(5'b00100, ty(0, 0, B, 0, 0), op(0, 0, 3, 0, 0), 5'b11111, 5'b00100));
    for (int s = 0; s < 4; s++)
      tb.push_back(cy(5'b00101, ty(0, 0, B, 0, H), op(0, 0, 3, 0, 3), 5'b10111, 5'b00000));
    tb.push_back(cy(5'b00101, ty(0, 0, B, 0, H), op(0, 0, 3, 0, 3), 5'b11111, 5'b00100));
    tb.push_back(cy(5'b00101, ty(0, 0, T, 0, H), op(0, 0, 3, 0, 3), 5'b11111, 5'b00100));
    tb.push_back(cy(5'b00001, ty(0, 0, 0, 0, H), op(0, 0, 0, 0, 3), 5'b11111, 5'b00001));
    tb.push_back(cy(5'b00001, ty(0, 0, 0, 0, T), op(0, 0, 0, 0, 3), 5'b11111, 5'b00001));
    tb.push_back(cy(5'b00000, ty(0, 0, 0, 0, 0), op(0, 0, 0, 0, 0), 5'b11111, 5'b00000));
    foreach (tb[k]) begin
      @(negedge clk); drive(tb[k]); #1;
      checks++;
      if (in_grant !== tb[k].g) begin
        failures++; $display("FAIL backpressure_grant cyc=%0d got=%b exp=%b", k, in_grant, tb[k].g);
      end
      push_expect(tb[k].g, tb[k].o);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_valid !== e.v || xbar_sel !== e.x) begin
        failures++;
        $display("FAIL backpressure_out cyc=%0d got v=%b x=%h exp v=%b x=%h", k, out_valid, xbar_sel, e.v, e.x);
      end
    end
  endtask

  task automatic test_parallel();
    cyc_t tb[$];
    exp_t e;
    tb.push_back(cy(5'b11111, ty(H, H, H, H, H), op(0, 4, 3, 2, 1), 5'b11111, 5'b11111));
    tb.push_back(cy(5'b11111, ty(T, T, T, T, T), op(0, 4, 3, 2, 1), 5'b11111, 5'b11111));
    tb.push_back(cy(5'b00000, ty(0, 0, 0, 0, 0), op(0, 0, 0, 0, 0), 5'b11111, 5'b00000));
    foreach (tb[k]) begin
      @(negedge clk); drive(tb[k]); #1;
      checks++;
      if (in_grant !== tb[k].g) begin
        failures++; $display("FAIL parallel_grant cyc=%0d got=%b exp=%b", k, in_grant, tb[k].g);
      end
      push_expect(tb[k].g, tb[k].o);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_valid !== e.v || xbar_sel !== e.x) begin
        failures++;
        $display("FAIL parallel_out cyc=%0d got v=%b x=%h exp v=%b x=%h", k, out_valid, xbar_sel, e.v, e.x);
      end
    end
    checks++;
    if (proto_err !== 1'b0) begin
      failures++; $display("FAIL legal_traffic_proto got=%b exp=0", proto_err);
    end
  endtask

  task automatic test_reset_midpacket();
    cyc_t tb[$];
    exp_t e;
    // Lock output 4 to input 1, then reset in the middle of the packet.
    @(negedge clk);
    drive(cy(5'b00010, ty(0, 0, 0, H, 0), op(0, 0, 0, 4, 0), 5'b11111, 5'b00010)); #1;
    checks++;
    if (in_grant !== 5'b00010) begin
      failures++; $display("FAIL midrst_head_grant got=%b exp=00010", in_grant);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(cy(5'b00010, ty(0, 0, 0, B, 0), op(0, 0, 0, 4, 0), 5'b11111, 5'b00000)); #1;
    checks++;
    if (in_grant !== 5'b00000) begin
      failures++; $display("FAIL midrst_grant_in_reset got=%b exp=00000", in_grant);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 5'b00000 || xbar_sel !== '0) begin
      failures++; $display("FAIL midrst_regs got v=%b x=%h exp v=0 x=0", out_valid, xbar_sel);
    end
    sb.delete();
    xsel_model = '0;
    @(negedge clk);
    rst = 1'b0;
    // The BODY that was in flight is orphaned; the input must restart with a HEAD.
    tb.push_back(cy(5'b00010, ty(0, 0, 0, B, 0), op(0, 0, 0, 4, 0), 5'b11111, 5'b00000));
    tb.push_back(cy(5'b00010, ty(0, 0, 0, H, 0), op(0, 0, 0, 4, 0), 5'b11111, 5'b00010));
    tb.push_back(cy(5'b00010, ty(0, 0, 0, T, 0), op(0, 0, 0, 4, 0), 5'b11111, 5'b00010));
    tb.push_back(cy(5'b00000, ty(0, 0, 0, 0, 0), op(0, 0, 0, 0, 0), 5'b11111, 5'b00000));
    foreach (tb[k]) begin
      if (k != 0) @(negedge clk);
      drive(tb[k]); #1;
      checks++;
      if (in_grant !== tb[k].g) begin
        failures++; $display("FAIL midrst_grant cyc=%0d got=%b exp=%b", k, in_grant, tb[k].g);
      end
      push_expect(tb[k].g, tb[k].o);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_valid !== e.v || xbar_sel !== e.x) begin
        failures++;
        $display("FAIL midrst_out cyc=%0d got v=%b x=%h exp v=%b x=%h", k, out_valid, xbar_sel, e.v, e.x);
      end
      checks++;
      if (proto_err !== exp_proto) begin
        failures++; $display("FAIL proto_err_sticky cyc=%0d got=%b exp=%b", k, proto_err, exp_proto);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (proto_err !== 1'b0) begin
      failures++; $display("FAIL proto_err_clear got=%b exp=0", proto_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
`ifdef SA_PROTO_CHECK_EN
    exp_proto = 1'b1;
`else
    exp_proto = 1'b0;
`endif
    xsel_model = '0;
    test_reset();
    test_single_packet();
    test_contention();
    test_lock_hold();
    test_backpressure();
    test_parallel();
    test_reset_midpacket();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
